// File: rtl/acc_bank_pkg.sv
// rtl/acc_bank_pkg.sv - shared types and defaults for the accumulator bank
//
// Purpose: state encoding, default geometry and the row-width helper that the
// accumulator bank shares with the MAC array.
// Ports: none (package).

package acc_bank_pkg;

  localparam int DEF_NUM_LANES = 16;
  localparam int DEF_ACC_W     = 24;
  localparam int DEF_DEPTH     = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Width of one accumulator row; the MAC array sizes its psum buses with this.
  function automatic int row_w(input int lanes, input int acc_w);
    return lanes * acc_w;
  endfunction

endpackage

// File: rtl/acc_row_mem.sv
// rtl/acc_row_mem.sv - DEPTH x row storage with per-row valid bits
//
// Purpose: row storage for the accumulator bank. The array itself is never
// reset; a per-row valid vector gates both read ports so a bulk clear of the
// valid bits makes every row read as zero in a single cycle.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset (valid bits only)
//   i_clr               clear all valid bits
//   i_we/i_waddr/i_wdata write port; sets the valid bit of the written row
//   i_raddr_a/o_rdata_a combinational read port (MAC feedback)
//   i_raddr_b/o_rdata_b combinational read port (drain)

module acc_row_mem
  import acc_bank_pkg::*;
#(
  parameter  int ROW_W = row_w(DEF_NUM_LANES, DEF_ACC_W),
  parameter  int DEPTH = DEF_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [ROW_W-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr_a,
  output logic [ROW_W-1:0] o_rdata_a,
  input  logic [AW-1:0]    i_raddr_b,
  output logic [ROW_W-1:0] o_rdata_b
);

  logic [ROW_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0] r_valid;

  // Data storage has no reset: stale contents are masked by r_valid.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // A write in the same edge as a clear still marks its row valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else begin
      if (i_clr) begin
        r_valid <= '0;
      end
      if (i_we) begin
        r_valid[i_waddr] <= 1'b1;
      end
    end
  end

  assign o_rdata_a = r_valid[i_raddr_a] ? r_mem[i_raddr_a] : '0;
  assign o_rdata_b = r_valid[i_raddr_b] ? r_mem[i_raddr_b] : '0;

endmodule

// File: rtl/acc_bank.sv
// rtl/acc_bank.sv - accumulator buffer between MAC array and PPU
//
// Purpose: holds DEPTH rows of partial sums, feeds the current row back to the
// MAC for read-modify-write accumulation, and on tile_end drains all rows to
// the PPU over a valid/ready handshake.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 begin a tile (IDLE only)
//   mac_valid/mac_psum_in updated row for the current write address
//   to_mac                current row fed back to the MAC (ACCUM only)
//   tile_end              end accumulation, begin drain (ACCUM only)
//   ppu_valid/ppu_ready   drain handshake
//   ppu_data/ppu_addr     drained row and its index
//   ppu_last              current drain row is DEPTH-1
//   busy                  not IDLE
//   done                  one-cycle pulse after the final drain transfer
//   err_overrun           sticky: mac_valid seen outside ACCUM

module acc_bank
  import acc_bank_pkg::*;
#(
  parameter  int NUM_LANES = DEF_NUM_LANES,
  parameter  int ACC_W     = DEF_ACC_W,
  parameter  int DEPTH     = DEF_DEPTH,
  localparam int AW        = $clog2(DEPTH),
  localparam int ROW_W     = row_w(NUM_LANES, ACC_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mac_valid,
  input  logic [ROW_W-1:0] mac_psum_in,
  output logic [ROW_W-1:0] to_mac,
  input  logic             tile_end,
  output logic             ppu_valid,
  input  logic             ppu_ready,
  output logic [ROW_W-1:0] ppu_data,
  output logic [AW-1:0]    ppu_addr,
  output logic             ppu_last,
  output logic             busy,
  output logic             done,
  output logic             err_overrun
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [AW-1:0]    r_wr_addr;
  logic [AW-1:0]    r_rd_addr;
  logic             r_done;
  logic             r_err;

  logic             w_we;
  logic             w_clr;
  logic             w_xfer;
  logic             w_drain_go;
  logic             w_rd_last;
  logic [ROW_W-1:0] w_rdata_a;
  logic [ROW_W-1:0] w_rdata_b;

  assign w_rd_last = (r_rd_addr == LAST_ADDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and per-cycle strobes. In IDLE, start takes priority and any
  // concurrent tile_end is simply not looked at.
  always_comb begin
    w_state_nxt = r_state;
    w_we        = 1'b0;
    w_clr       = 1'b0;
    w_xfer      = 1'b0;
    w_drain_go  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_ACCUM;
          w_clr       = 1'b1;
        end
      end
      ST_ACCUM: begin
        // A write coinciding with tile_end still lands before the drain reads.
        w_we = mac_valid;
        if (tile_end) begin
          w_state_nxt = ST_DRAIN;
          w_drain_go  = 1'b1;
        end
      end
      ST_DRAIN: begin
        w_xfer = ppu_ready;
        if (ppu_ready && w_rd_last) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_addr <= '0;
      r_rd_addr <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      if (w_clr) begin
        r_wr_addr <= '0;
      end else if (w_we) begin
        r_wr_addr <= (r_wr_addr == LAST_ADDR) ? '0 : r_wr_addr + 1'b1;
      end

      if (w_drain_go) begin
        r_rd_addr <= '0;
      end else if (w_xfer) begin
        r_rd_addr <= w_rd_last ? '0 : r_rd_addr + 1'b1;
      end

      r_done <= w_xfer && w_rd_last;

      // A stray mac_valid in the same cycle as an accepted start still flags.
      if (mac_valid && (r_state != ST_ACCUM)) begin
        r_err <= 1'b1;
      end else if (w_clr) begin
        r_err <= 1'b0;
      end
    end
  end

  acc_row_mem #(
    .ROW_W (ROW_W),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (w_clr),
    .i_we      (w_we),
    .i_waddr   (r_wr_addr),
    .i_wdata   (mac_psum_in),
    .i_raddr_a (r_wr_addr),
    .o_rdata_a (w_rdata_a),
    .i_raddr_b (r_rd_addr),
    .o_rdata_b (w_rdata_b)
  );

  assign to_mac      = (r_state == ST_ACCUM) ? w_rdata_a : '0;
  assign ppu_valid   = (r_state == ST_DRAIN);
  assign ppu_data    = (r_state == ST_DRAIN) ? w_rdata_b : '0;
  assign ppu_addr    = r_rd_addr;
  assign ppu_last    = (r_state == ST_DRAIN) && w_rd_last;
  assign busy        = (r_state != ST_IDLE);
  assign done        = r_done;
  assign err_overrun = r_err;

endmodule
